// File: rtl/sega_joy_scan_if.sv
// Pad-side bus of the Sega/Atari joystick scanner: tick/pins in, select, button words, types and frame strobe out.
// master = the scanner, slave = the core/pad side that drives tick_i and joy_i.
interface sega_joy_scan_if #(
    parameter int NUM_PORTS = 2
);
    logic                      tick_i;
    logic [NUM_PORTS*6-1:0]    joy_i;
    logic                      sel_o;
    logic [NUM_PORTS*12-1:0]   joy_o;
    logic [NUM_PORTS*2-1:0]    type_o;
    logic                      frame_o;

    modport master (
        input  tick_i, joy_i,
        output sel_o, joy_o, type_o, frame_o
    );

    modport slave (
        output tick_i, joy_i,
        input  sel_o, joy_o, type_o, frame_o
    );
endinterface

// File: rtl/sega_joy_scan.sv
// Multi-port Sega/Atari DB9 scanner: tick-paced select sequence, pad classification, atomic per-port commit.
// Optional macro JOY_SYNC_EN: adds a 2-flop synchroniser on joy_i (tick spacing must then be >= 3 clocks).
module sega_joy_port (
    input  logic        clk_i,
    input  logic        res_n_i,
    input  logic        s_ph2,
    input  logic        s_ph3,
    input  logic        s_ph5,
    input  logic        s_ph6,
    input  logic        s_commit,
    input  logic [5:0]  pins,      // {p9, p6, right, left, down, up}
    output logic [11:0] joy,
    output logic [1:0]  pad_type
);
    logic [11:0] shadow;
    logic        md;
    logic        six;

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            shadow   <= '1;
            md       <= 1'b0;
            six      <= 1'b0;
            joy      <= '1;
            pad_type <= 2'b00;
        end else begin
            if (s_ph2) begin
                shadow[5:0] <= pins;
                six         <= 1'b0;
            end
            // Left+right both low with select low only happens on an MD pad.
            if (s_ph3) begin
                if (pins[3:2] == 2'b00) begin
                    shadow[7:6] <= pins[5:4];
                    md          <= 1'b1;
                end else begin
                    shadow[7:6] <= 2'b11;
                    md          <= 1'b0;
                end
            end
            if (s_ph5 && pins[3:0] == 4'b0000)
                six <= 1'b1;
            if (s_ph6)
                shadow[11:8] <= six ? pins[3:0] : 4'hF;
            if (s_commit) begin
                joy      <= shadow;
                pad_type <= {six, md & ~six};
            end
        end
    end
endmodule

module sega_joy_scan #(
    parameter int NUM_PORTS   = 2,
    parameter int SCAN_PERIOD = 256,
    parameter int CNT_W       = 8
) (
    input  logic                clk_i,
    input  logic                res_n_i,
    sega_joy_scan_if.master     bus
);
    logic [CNT_W-1:0]                cnt;
    logic [CNT_W-1:0]                cnt_nxt;
    logic [7:0]                      is_ph;
    logic                            sel_q;
    logic                            sel_nxt;
    logic                            frame_q;
    logic                            frame_nxt;
    logic [NUM_PORTS-1:0][5:0]       pins;
    logic [NUM_PORTS-1:0][11:0]      joy_w;
    logic [NUM_PORTS-1:0][1:0]       type_w;

`ifdef JOY_SYNC_EN
    logic [NUM_PORTS*6-1:0] sync_q1;
    logic [NUM_PORTS*6-1:0] sync_q2;

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= bus.joy_i;
            sync_q2 <= sync_q1;
        end
    end
    assign pins = sync_q2;
`else
    assign pins = bus.joy_i;
`endif

    // Phase counter is the FSM state; it only moves on ticks and never stalls.
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) cnt <= '0;
        else          cnt <= cnt_nxt;
    end

    always_comb begin
        cnt_nxt = cnt;
        if (bus.tick_i)
            cnt_nxt = (cnt == CNT_W'(SCAN_PERIOD - 1)) ? '0 : cnt + CNT_W'(1);
    end

    // Select toggles low/high over phases 0..7 (sel <= phase LSB), then idles high.
    always_comb begin
        for (int k = 0; k < 8; k++)
            is_ph[k] = bus.tick_i && (cnt == CNT_W'(k));
        sel_nxt   = (|is_ph) ? cnt[0] : sel_q;
        frame_nxt = is_ph[7];
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            sel_q   <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            sel_q   <= sel_nxt;
            frame_q <= frame_nxt;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        sega_joy_port u_port (
            .clk_i    (clk_i),
            .res_n_i  (res_n_i),
            .s_ph2    (is_ph[2]),
            .s_ph3    (is_ph[3]),
            .s_ph5    (is_ph[5]),
            .s_ph6    (is_ph[6]),
            .s_commit (is_ph[7]),
            .pins     (pins[p]),
            .joy      (joy_w[p]),
            .pad_type (type_w[p])
        );
    end

    assign bus.sel_o   = sel_q;
    assign bus.frame_o = frame_q;
    assign bus.joy_o   = joy_w;
    assign bus.type_o  = type_w;
endmodule

// File: tb/tb_sega_joy_scan.sv
// Randomised bench for sega_joy_scan: behavioural pad models on the DB9 pins and a pad-level expected-word model.
module tb_sega_joy_scan;
    localparam int NP     = 2;
    localparam int P      = 10;
    localparam int CW     = 4;
    localparam int PAD_TO = 6;   // pad's select-high timeout, in clocks

    localparam int K_NONE = 0, K_SMS = 1, K_MD3 = 2, K_MD6 = 3;

    logic clk = 1'b0;
    logic res_n;
    always #5 clk = ~clk;

    sega_joy_scan_if #(.NUM_PORTS(NP)) bus();

    sega_joy_scan #(.NUM_PORTS(NP), .SCAN_PERIOD(P), .CNT_W(CW)) dut (
        .clk_i   (clk),
        .res_n_i (res_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int phase    = 0;
    int gap      = 3;

    int          pad_kind [NP];
    logic [11:0] pad_btn  [NP];   // {Mode,X,Y,Z,Start,A,C,B,R,L,D,U}, active-low

    // Pad-side view of the select line: count lows since the pad last timed out.
    int   lows     = 0;
    int   hi_run   = 0;
    logic last_sel = 1'b1;

    always @(negedge clk) begin
        if (!bus.sel_o && last_sel) lows <= lows + 1;
        if (bus.sel_o) begin
            hi_run <= hi_run + 1;
            if (hi_run >= PAD_TO - 1) lows <= 0;
        end else begin
            hi_run <= 0;
        end
        last_sel <= bus.sel_o;
    end

    function automatic logic [5:0] pad_pins(int kind, logic [11:0] b, logic sel, int nlow);
        logic [5:0] v;
        v = 6'h3F;
        case (kind)
            K_SMS: v = b[5:0];
            K_MD3: v = sel ? b[5:0] : {b[7:6], 2'b00, b[1:0]};
            K_MD6: begin
                if (sel)            v = (nlow == 3) ? {b[5:4], b[11:8]} : b[5:0];
                else if (nlow == 3) v = {b[7:6], 4'h0};
                else if (nlow >= 4) v = {b[7:6], 4'hF};
                else                v = {b[7:6], 2'b00, b[1:0]};
            end
            default: v = 6'h3F;
        endcase
        return v;
    endfunction

    logic [NP-1:0][5:0] pins_w;
    always_comb begin
        pins_w = '1;
        for (int p = 0; p < NP; p++)
            pins_w[p] = pad_pins(pad_kind[p], pad_btn[p], bus.sel_o, lows);
    end
    assign bus.joy_i = pins_w;

    // What the core should see for a given pad, from the pad's capabilities.
    function automatic logic [11:0] exp_word(int kind, logic [11:0] b);
        case (kind)
            K_SMS:   return {6'h3F, b[5:0]};
            K_MD3:   return {4'hF, b[7:0]};
            K_MD6:   return b;
            default: return 12'hFFF;
        endcase
    endfunction

    function automatic logic [1:0] exp_type(int kind);
        case (kind)
            K_MD3:   return 2'b01;
            K_MD6:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [11:0] rand_btn();
        logic [11:0] b;
        b = 12'($urandom);
        if (b[1:0] == 2'b00) b[1] = 1'b1;  // up+down never together
        if (b[3:2] == 2'b00) b[3] = 1'b1;  // left+right never together
        return b;
    endfunction

    // Called just after a negedge; one tick, then checks select/frame after it was consumed.
    task automatic do_tick();
        int   ph;
        logic es;
        ph = phase;
        bus.tick_i = 1'b1;
        @(negedge clk);
        bus.tick_i = 1'b0;
        es = (ph < 8) ? 1'((ph % 2)) : 1'b1;
        checks++;
        if (bus.sel_o !== es) begin
            failures++;
            $display("FAIL sel_after_phase%0d got=%b exp=%b", ph, bus.sel_o, es);
        end
        checks++;
        if (bus.frame_o !== (ph == 7)) begin
            failures++;
            $display("FAIL frame_after_phase%0d got=%b exp=%b", ph, bus.frame_o, (ph == 7));
        end
        phase = (ph + 1) % P;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic run_scan();
        for (int i = 0; i < P; i++) do_tick();
    endtask

    task automatic test_reset();
        bus.tick_i = 1'b0;
        res_n = 1'b1;
        for (int p = 0; p < NP; p++) begin
            pad_kind[p] = K_MD6;
            pad_btn[p]  = rand_btn();
        end
        #2 res_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin  // ticks under reset must do nothing
            bus.tick_i = 1'b1; @(negedge clk); bus.tick_i = 1'b0; @(negedge clk);
        end
        checks++;
        if (bus.sel_o !== 1'b1 || bus.frame_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_sel_frame got=%b%b exp=10", bus.sel_o, bus.frame_o);
        end
        checks++;
        if (bus.joy_o !== '1 || bus.type_o !== '0) begin
            failures++;
            $display("FAIL reset_joy_type got=%h/%h exp=%h/0", bus.joy_o, bus.type_o, {NP*12{1'b1}});
        end
        res_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (bus.sel_o !== 1'b1 || bus.frame_o !== 1'b0 || bus.joy_o !== '1 || bus.type_o !== '0) begin
            failures++;
            $display("FAIL no_tick_hold got sel=%b frame=%b joy=%h type=%h exp sel=1 frame=0 joy=all1 type=0",
                     bus.sel_o, bus.frame_o, bus.joy_o, bus.type_o);
        end
        phase = 0;
    endtask

    task automatic test_sms();
        pad_kind[0] = K_SMS;  pad_btn[0] = 12'hFEE;
        pad_kind[1] = K_NONE; pad_btn[1] = 12'hFFF;
        repeat (PAD_TO + 2) @(negedge clk);
        run_scan();
        checks++;
        if (bus.joy_o[11:0] !== 12'hFEE || bus.type_o[1:0] !== 2'b00) begin
            failures++;
            $display("FAIL sms_port0 got=%h/%b exp=FEE/00", bus.joy_o[11:0], bus.type_o[1:0]);
        end
        checks++;
        if (bus.joy_o[23:12] !== 12'hFFF || bus.type_o[3:2] !== 2'b00) begin
            failures++;
            $display("FAIL sms_port1_empty got=%h/%b exp=FFF/00", bus.joy_o[23:12], bus.type_o[3:2]);
        end
    endtask

    task automatic test_md3();
        pad_kind[0] = K_NONE; pad_btn[0] = 12'hFFF;
        pad_kind[1] = K_MD3;  pad_btn[1] = 12'hFBF;
        run_scan();
        checks++;
        if (bus.joy_o[23:12] !== 12'hFBF || bus.type_o[3:2] !== 2'b01) begin
            failures++;
            $display("FAIL md3_port1 got=%h/%b exp=FBF/01", bus.joy_o[23:12], bus.type_o[3:2]);
        end
        checks++;
        if (bus.joy_o[11:0] !== 12'hFFF || bus.type_o[1:0] !== 2'b00) begin
            failures++;
            $display("FAIL md3_port0_empty got=%h/%b exp=FFF/00", bus.joy_o[11:0], bus.type_o[1:0]);
        end
    endtask

    task automatic test_md6_hotswap();
        pad_kind[0] = K_MD6;  pad_btn[0] = 12'hEFF;
        pad_kind[1] = K_NONE; pad_btn[1] = 12'hFFF;
        run_scan();
        checks++;
        if (bus.joy_o[11:8] !== 4'hE || bus.type_o[1:0] !== 2'b10) begin
            failures++;
            $display("FAIL md6_port0 got=%h/%b exp=E/10", bus.joy_o[11:8], bus.type_o[1:0]);
        end
        pad_kind[0] = K_NONE;
        run_scan();
        checks++;
        if (bus.joy_o[11:0] !== 12'hFFF || bus.type_o[1:0] !== 2'b00) begin
            failures++;
            $display("FAIL unplug_port0 got=%h/%b exp=FFF/00", bus.joy_o[11:0], bus.type_o[1:0]);
        end
    endtask

    task automatic test_reset_mid_scan();
        pad_kind[0] = K_MD3; pad_btn[0] = 12'hFBF;
        for (int i = 0; i < 5; i++) do_tick();   // phases 0..4
        res_n = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.joy_o[11:0] !== 12'hFFF || bus.frame_o !== 1'b0 || bus.sel_o !== 1'b1) begin
            failures++;
            $display("FAIL midscan_reset got joy=%h frame=%b sel=%b exp FFF 0 1",
                     bus.joy_o[11:0], bus.frame_o, bus.sel_o);
        end
        res_n = 1'b1;
        phase = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 7; i++) do_tick();   // phases 0..6, no commit yet
        checks++;
        if (bus.joy_o[11:0] !== 12'hFFF) begin
            failures++;
            $display("FAIL midscan_no_early_commit got=%h exp=FFF", bus.joy_o[11:0]);
        end
        do_tick();                                // phase 7 commits
        checks++;
        if (bus.joy_o[11:0] !== 12'hFBF || bus.type_o[1:0] !== 2'b01) begin
            failures++;
            $display("FAIL midscan_next_commit got=%h/%b exp=FBF/01", bus.joy_o[11:0], bus.type_o[1:0]);
        end
        do_tick(); do_tick();
    endtask

    task automatic test_random();
        logic [11:0] ew;
        logic [1:0]  et;
        for (int s = 0; s < 12; s++) begin
            for (int p = 0; p < NP; p++) begin
                pad_kind[p] = int'($urandom_range(0, 3));
                pad_btn[p]  = rand_btn();
            end
            run_scan();
            for (int p = 0; p < NP; p++) begin
                ew = exp_word(pad_kind[p], pad_btn[p]);
                et = exp_type(pad_kind[p]);
                checks++;
                if (bus.joy_o[12*p +: 12] !== ew || bus.type_o[2*p +: 2] !== et) begin
                    failures++;
                    $display("FAIL random_scan%0d_port%0d kind=%0d btn=%h got=%h/%b exp=%h/%b",
                             s, p, pad_kind[p], pad_btn[p], bus.joy_o[12*p +: 12],
                             bus.type_o[2*p +: 2], ew, et);
                end
            end
        end
    endtask

    task automatic test_wrap_continuous();
        logic es;
        int   last_frame;
        last_frame = -1;
        for (int p = 0; p < NP; p++) pad_kind[p] = K_NONE;
        bus.tick_i = 1'b1;
        for (int i = 0; i < 3 * P; i++) begin
            @(negedge clk);
            es = (phase < 8) ? 1'((phase % 2)) : 1'b1;
            checks++;
            if (bus.sel_o !== es || bus.frame_o !== (phase == 7)) begin
                failures++;
                $display("FAIL wrap_cycle%0d_phase%0d got sel=%b frame=%b exp sel=%b frame=%b",
                         i, phase, bus.sel_o, bus.frame_o, es, (phase == 7));
            end
            if (bus.frame_o === 1'b1) begin
                if (last_frame >= 0) begin
                    checks++;
                    if (i - last_frame != P) begin
                        failures++;
                        $display("FAIL frame_period got=%0d exp=%0d", i - last_frame, P);
                    end
                end
                last_frame = i;
            end
            phase = (phase + 1) % P;
        end
        bus.tick_i = 1'b0;
        repeat (PAD_TO + 2) @(negedge clk);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sms();
        test_md3();
        test_md6_hotswap();
        test_reset_mid_scan();
        test_random();
        test_wrap_continuous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
